i2c_responder: RTL and testbench
================================

Name: i2c_responder

Overview:
- I2C target (slave) responder: the bus end that answers the team's I2C master controller.
- Watches the SCL/SDA pins, detects START, repeated START and STOP, and matches a 7-bit device address.
- On write transfers it ACKs and delivers each received byte. On read transfers it shifts out bytes supplied by the user logic and samples the master's ACK/NACK.
- Lets lab designs exercise the master end-to-end without an external part.

Parameters:
- DeviceAddress, 7'b1001000, 7-bit target address compared against the first byte after START.
- SyncStages, 2, synchronizer flops per bus line; minimum 2.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SCL  input  1  I2C clock pin, asynchronous.
- SDAin  input  1  I2C data pin as seen on the bus, asynchronous.
- SDAdrive  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- TxData  input  8  byte to send on a read; sampled only in the cycle TxRequest=1.
- TxRequest  output  1  one-cycle pulse; TxData is loaded into the shift register in this cycle.
- RxData  output  8  last byte received in a write transfer; held until the next one.
- RxValid  output  1  one-cycle pulse when RxData updates.
- Addressed  output  1  high from address match until STOP or START.

Behaviour:
- Reset (async, any state): state=IDLE; SDAdrive=0, TxRequest=0, RxValid=0, Addressed=0, RxData=8'h00; bit counter and shift register cleared.
- Input conditioning:
  - SCL and SDAin each pass through SyncStages flops, plus one history flop.
  - Events are sclRise, sclFall, start (SDA 1->0 while SCL=1) and stop (SDA 0->1 while SCL=1).
  - Event latency: SyncStages+1 clocks after the pin change.
  - Clock requirement: SCL high and low phases each ≥ 4 clock periods.
- Sampling and driving:
  - SDA is sampled on sclRise.
  - SDAdrive changes only on sclFall, except STOP/START, which release it immediately.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- start in any state -> ADDR: bit counter=0, Addressed=0, SDAdrive=0. This covers repeated START.
- stop in any state -> IDLE: SDAdrive=0, Addressed=0.
- ADDR:
  - Shift 8 bits, MSB first, on sclRise.
  - After the 8th rise, bits[7:1]==DeviceAddress -> ADDR_ACK with Addressed=1.
  - Mismatch -> WAIT_STOP; SDA is never driven.
- ADDR_ACK:
  - First sclFall: SDAdrive=1.
  - Next sclRise: ACK slot sampled by the master.
  - Following sclFall: if R/W=0, SDAdrive=0 and go to WR_BYTE.
  - If R/W=1: TxRequest pulses, TxData is loaded, SDAdrive=~TxData[7], go to RD_BYTE.
- WR_BYTE:
  - 8 sclRise samples.
  - On the 8th: RxData=shifted byte, RxValid=1 for one cycle, go to WR_ACK.
- WR_ACK: same ACK drive/release timing as ADDR_ACK, then back to WR_BYTE. Every byte is ACKed.
- RD_BYTE:
  - Each sclFall shifts and drives the next bit (SDAdrive = ~bit).
  - After the 8th bit's sclFall, SDAdrive=0 and go to RD_ACK.
- RD_ACK:
  - On sclRise, SDA=0 (ACK): on the next sclFall, TxRequest pulses, the next byte loads, and bit 7 is driven in RD_BYTE.
  - SDA=1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore SCL; leave only on start or stop.
- Simultaneous start and stop in the same cycle is impossible (both require an SDA edge); stop has priority if it is ever decoded.
- RxValid and TxRequest are never high in the same cycle.

Decomposition:
- Package i2c_pkg holds:
  - state encoding (3-bit localparams);
  - ACK=1'b0 and NACK=1'b1;
  - the default device address 7'b1001000.
- Sub-module i2c_line_sync (SyncStages synchronizer plus history flop; outputs level, rise and fall). It is instantiated once for SCL and once for SDA; start/stop are decoded in the parent.

Test Plan:
- Reset mid-transfer: assert Reset during the 4th address bit -> SDAdrive=0, Addressed=0, RxData=8'h00 immediately (no clock edge needed); the next START is handled normally.
- Write: START, 0x90, 0x3C, STOP with SCL period 24 clocks -> ACK low in both 9th slots; RxData=8'h3C; one RxValid pulse; Addressed falls at STOP.
- Wrong address: START, 0x92, 0x55, STOP -> SDAdrive stays 0 throughout, RxValid never pulses, Addressed stays 0.
- Read with master ACK then NACK: START, 0x91; TxData=8'hA5 then 8'h0F at each TxRequest -> SDA carries A5 then 0F MSB first; exactly 2 TxRequest pulses; after NACK, SDA is released and the block sits in WAIT_STOP until STOP.
- Repeated START: START, 0x90, 0x01, START, 0x91, read 1 byte NACK, STOP -> RxData=8'h01; one TxRequest; ADDR re-entered without passing through IDLE.
- Timing: measure SDAdrive rise after the 8th address sclFall at the pin -> exactly SyncStages+1 (=3) clocks; SDA never changes while SCL is high.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder.
// State encoding, ACK/NACK levels and the default device address.
package i2c_pkg;

    localparam logic [2:0] stIdle     = 3'd0;
    localparam logic [2:0] stAddr     = 3'd1;
    localparam logic [2:0] stAddrAck  = 3'd2;
    localparam logic [2:0] stWrByte   = 3'd3;
    localparam logic [2:0] stWrAck    = 3'd4;
    localparam logic [2:0] stRdByte   = 3'd5;
    localparam logic [2:0] stRdAck    = 3'd6;
    localparam logic [2:0] stWaitStop = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = stIdle,
        ADDR      = stAddr,
        ADDR_ACK  = stAddrAck,
        WR_BYTE   = stWrByte,
        WR_ACK    = stWrAck,
        RD_BYTE   = stRdByte,
        RD_ACK    = stRdAck,
        WAIT_STOP = stWaitStop
    } stateT;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] defaultAddress = 7'b1001000;

endpackage

// File: rtl/i2c_responder_if.sv
// Bus pins plus user-side byte handshake of the I2C responder.
// slave: responder side; master: bus/user side driving it.
interface i2c_responder_if;

    logic       SCL;
    logic       SDAin;
    logic       SDAdrive;
    logic [7:0] TxData;
    logic       TxRequest;
    logic [7:0] RxData;
    logic       RxValid;
    logic       Addressed;

    modport slave (
        input  SCL, SDAin, TxData,
        output SDAdrive, TxRequest,
        output RxData, RxValid, Addressed
    );

    modport master (
        output SCL, SDAin, TxData,
        input  SDAdrive, TxRequest,
        input  RxData, RxValid, Addressed
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer chain plus history flop for one async bus line.
// Ports: clock, Reset, pin in; level, rise, fall out.
module i2c_line_sync #(
    parameter int SyncStages = 2
) (
    input  logic clock,
    input  logic Reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SyncStages-1:0] syncQ;
    logic                  history;

    // Cleared to 0: a line idling high afterwards shows as a
    // rise on both lines at once, which decodes as a harmless STOP.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            syncQ   <= '0;
            history <= 1'b0;
        end else begin
            syncQ   <= {syncQ[SyncStages-2:0], pin};
            history <= syncQ[SyncStages-1];
        end
    end

    assign level = syncQ[SyncStages-1];
    assign rise  = level & ~history;
    assign fall  = ~level & history;

endmodule

// File: rtl/i2c_responder.sv
// I2C target: START/STOP detect, address match, byte write/read.
// Ports: clock, Reset, bus (SCL/SDA pins, Tx/Rx byte handshake).
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DeviceAddress = defaultAddress,
    parameter int         SyncStages    = 2
) (
    input logic              clock,
    input logic              Reset,
    i2c_responder_if.slave   bus
);

    logic sclLevel, sclRise, sclFall;
    logic sdaLevel, sdaRise, sdaFall;
    logic start, stop;

    i2c_line_sync #(.SyncStages(SyncStages)) sclSync (
        .clock (clock),
        .Reset (Reset),
        .pin   (bus.SCL),
        .level (sclLevel),
        .rise  (sclRise),
        .fall  (sclFall)
    );

    i2c_line_sync #(.SyncStages(SyncStages)) sdaSync (
        .clock (clock),
        .Reset (Reset),
        .pin   (bus.SDAin),
        .level (sdaLevel),
        .rise  (sdaRise),
        .fall  (sdaFall)
    );

    assign start = sdaFall & sclLevel;
    assign stop  = sdaRise & sclLevel;

    stateT       state, stateN;
    logic [3:0]  bitCnt, bitCntN;
    logic [7:0]  shiftQ, shiftN;
    logic [7:0]  rxDataQ, rxDataN;
    logic        rxValidQ, rxValidN;
    logic        driveQ, driveN;
    logic        addrQ, addrN;
    logic        txReq;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftQ   <= '0;
            rxDataQ  <= '0;
            rxValidQ <= 1'b0;
            driveQ   <= 1'b0;
            addrQ    <= 1'b0;
        end else begin
            state    <= stateN;
            bitCnt   <= bitCntN;
            shiftQ   <= shiftN;
            rxDataQ  <= rxDataN;
            rxValidQ <= rxValidN;
            driveQ   <= driveN;
            addrQ    <= addrN;
        end
    end

    always_comb begin
        stateN   = state;
        bitCntN  = bitCnt;
        shiftN   = shiftQ;
        rxDataN  = rxDataQ;
        rxValidN = 1'b0;
        driveN   = driveQ;
        addrN    = addrQ;
        txReq    = 1'b0;

        if (stop) begin
            stateN = IDLE;
            driveN = 1'b0;
            addrN  = 1'b0;
        end else if (start) begin
            stateN  = ADDR;
            bitCntN = '0;
            driveN  = 1'b0;
            addrN   = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;

                ADDR: begin
                    if (sclRise) begin
                        shiftN  = {shiftQ[6:0], sdaLevel};
                        bitCntN = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            if (shiftN[7:1] == DeviceAddress) begin
                                stateN = ADDR_ACK;
                                addrN  = 1'b1;
                            end else begin
                                stateN = WAIT_STOP;
                            end
                        end
                    end
                end

                // First fall pulls SDA low; the fall after the ACK
                // slot either releases it or presents the read MSB.
                // shiftQ[0] still holds the R/W bit here.
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!driveQ) begin
                            driveN = 1'b1;
                        end else if (!shiftQ[0]) begin
                            driveN  = 1'b0;
                            bitCntN = '0;
                            stateN  = WR_BYTE;
                        end else begin
                            txReq   = 1'b1;
                            shiftN  = bus.TxData;
                            driveN  = ~bus.TxData[7];
                            bitCntN = 4'd1;
                            stateN  = RD_BYTE;
                        end
                    end
                end

                WR_BYTE: begin
                    if (sclRise) begin
                        shiftN  = {shiftQ[6:0], sdaLevel};
                        bitCntN = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            rxDataN  = shiftN;
                            rxValidN = 1'b1;
                            stateN   = WR_ACK;
                        end
                    end
                end

                WR_ACK: begin
                    if (sclFall) begin
                        if (!driveQ) begin
                            driveN = 1'b1;
                        end else begin
                            driveN  = 1'b0;
                            bitCntN = '0;
                            stateN  = WR_BYTE;
                        end
                    end
                end

                // bitCnt counts bits already presented on SDA.
                RD_BYTE: begin
                    if (sclFall) begin
                        if (bitCnt == 4'd8) begin
                            driveN = 1'b0;
                            stateN = RD_ACK;
                        end else begin
                            shiftN  = {shiftQ[6:0], 1'b0};
                            driveN  = ~shiftQ[6];
                            bitCntN = bitCnt + 4'd1;
                        end
                    end
                end

                // Entered on a fall, so the next fall always follows
                // an ACK rise; a NACK leaves before it.
                RD_ACK: begin
                    if (sclRise && sdaLevel == NACK) begin
                        stateN = WAIT_STOP;
                    end else if (sclFall) begin
                        txReq   = 1'b1;
                        shiftN  = bus.TxData;
                        driveN  = ~bus.TxData[7];
                        bitCntN = 4'd1;
                        stateN  = RD_BYTE;
                    end
                end

                WAIT_STOP: ;

                default: stateN = IDLE;
            endcase
        end
    end

    assign bus.SDAdrive  = driveQ;
    assign bus.TxRequest = txReq;
    assign bus.RxData    = rxDataQ;
    assign bus.RxValid   = rxValidQ;
    assign bus.Addressed = addrQ;

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder with an RxData scoreboard.
// Bit-level I2C master model drives SCL/SDA on clock negedges.
module tb_i2c_responder;
    import i2c_pkg::*;

    logic clock = 1'b0;
    logic Reset;
    logic sclM;
    logic sdaM;
    logic [7:0] txFront = 8'hFF;

    logic [7:0] expRx[$];
    logic [7:0] txQ[$];

    int nPass = 0;
    int nTotal = 0;
    int rxCount = 0;
    int txCount = 0;
    int overlap = 0;
    int sdaHighChg = 0;
    logic sawDrive = 1'b0;
    logic sclPrev = 1'b1;
    logic drvPrev = 1'b0;

    i2c_responder_if bus ();

    assign bus.SCL    = sclM;
    assign bus.SDAin  = sdaM & ~bus.SDAdrive;
    assign bus.TxData = txFront;

    i2c_responder #(
        .DeviceAddress (7'b1001000),
        .SyncStages    (2)
    ) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nTotal++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h",
                      name, got, exp);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic refreshTx();
        txFront = (txQ.size() > 0) ? txQ[0] : 8'hFF;
    endtask

    // Scoreboard: every RxValid pulse pops one expected byte.
    always @(negedge clock) begin
        if (!Reset && bus.RxValid) begin
            rxCount++;
            if (expRx.size() == 0) begin
                check("rx unexpected", 32'd1, 32'd0);
            end else begin
                check("rxData", {24'd0, bus.RxData},
                      {24'd0, expRx.pop_front()});
            end
        end
        if (bus.RxValid && bus.TxRequest) overlap++;
        if (bus.SDAdrive) sawDrive = 1'b1;
        if (sclM && sclPrev && bus.SDAdrive != drvPrev)
            sdaHighChg++;
        sclPrev = sclM;
        drvPrev = bus.SDAdrive;
    end

    // TxData shows the queue head; advance once the load edge passed.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.TxRequest) begin
                txCount++;
                @(posedge clock);
                #1;
                if (txQ.size() > 0) txQ.delete(0);
                refreshTx();
            end
        end
    end

    task automatic bitSlot(input logic b);
        waitClk(6);
        sdaM = b;
        waitClk(6);
        sclM = 1'b1;
        waitClk(12);
        sclM = 1'b0;
    endtask

    task automatic startCond();
        sdaM = 1'b0;
        waitClk(6);
        sclM = 1'b0;
    endtask

    task automatic repStart();
        waitClk(6);
        sdaM = 1'b1;
        waitClk(6);
        sclM = 1'b1;
        waitClk(6);
        sdaM = 1'b0;
        waitClk(6);
        sclM = 1'b0;
    endtask

    task automatic stopCond();
        waitClk(6);
        sdaM = 1'b0;
        waitClk(6);
        sclM = 1'b1;
        waitClk(6);
        sdaM = 1'b1;
        waitClk(12);
    endtask

    // lat: clocks from the 8th fall at the pin until SDAdrive=1.
    task automatic writeByte(input logic [7:0] b,
                             output logic ack,
                             output int lat);
        for (int i = 7; i >= 0; i--) bitSlot(b[i]);
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (lat < 0 && bus.SDAdrive) lat = k;
        end
        sdaM = 1'b1;
        waitClk(6);
        sclM = 1'b1;
        waitClk(6);
        ack = bus.SDAin;
        waitClk(6);
        sclM = 1'b0;
    endtask

    task automatic readByte(input logic ackBit,
                            output logic [7:0] b);
        waitClk(2);
        sdaM = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            waitClk(4 + ((i == 7) ? 0 : 2));
            sclM = 1'b1;
            waitClk(6);
            b[i] = bus.SDAin;
            waitClk(6);
            sclM = 1'b0;
        end
        waitClk(6);
        sdaM = ackBit;
        waitClk(6);
        sclM = 1'b1;
        waitClk(12);
        sclM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic       ack;
        int         lat;
        logic [7:0] rb;
        int         txBase;

        Reset = 1'b0;
        sclM  = 1'b1;
        sdaM  = 1'b1;
        #2 Reset = 1'b1;
        waitClk(3);
        check("reset SDAdrive", {31'd0, bus.SDAdrive}, 32'd0);
        check("reset Addressed", {31'd0, bus.Addressed}, 32'd0);
        check("reset RxData", {24'd0, bus.RxData}, 32'd0);
        check("reset TxRequest", {31'd0, bus.TxRequest}, 32'd0);
        Reset = 1'b0;
        waitClk(10);

        // Write 0x90, 0x3C
        startCond();
        writeByte(8'h90, ack, lat);
        check("wr addr ack", {31'd0, ack}, {31'd0, ACK});
        check("ack drive latency", lat, 3);
        check("wr Addressed", {31'd0, bus.Addressed}, 32'd1);
        expRx.push_back(8'h3C);
        writeByte(8'h3C, ack, lat);
        check("wr data ack", {31'd0, ack}, {31'd0, ACK});
        stopCond();
        check("wr Addressed stop", {31'd0, bus.Addressed}, 32'd0);
        check("wr RxData held", {24'd0, bus.RxData}, 32'h3C);
        check("wr rx pulses", rxCount, 1);

        // Wrong address 0x92
        sawDrive = 1'b0;
        startCond();
        writeByte(8'h92, ack, lat);
        check("bad addr nack", {31'd0, ack}, 32'd1);
        check("bad Addressed", {31'd0, bus.Addressed}, 32'd0);
        writeByte(8'h55, ack, lat);
        check("bad data nack", {31'd0, ack}, 32'd1);
        stopCond();
        check("bad no drive", {31'd0, sawDrive}, 32'd0);
        check("bad rx pulses", rxCount, 1);

        // Read A5 (ACK) then 0F (NACK)
        txQ.push_back(8'hA5);
        txQ.push_back(8'h0F);
        refreshTx();
        txBase = txCount;
        startCond();
        writeByte(8'h91, ack, lat);
        check("rd addr ack", {31'd0, ack}, {31'd0, ACK});
        readByte(ACK, rb);
        check("rd byte0", {24'd0, rb}, 32'hA5);
        readByte(NACK, rb);
        check("rd byte1", {24'd0, rb}, 32'h0F);
        check("rd txreq count", txCount - txBase, 2);
        sawDrive = 1'b0;
        for (int i = 0; i < 9; i++) bitSlot(1'b1);
        check("waitstop no drive", {31'd0, sawDrive}, 32'd0);
        check("waitstop no txreq", txCount - txBase, 2);
        check("waitstop Addressed", {31'd0, bus.Addressed}, 32'd1);
        stopCond();
        check("rd Addressed stop", {31'd0, bus.Addressed}, 32'd0);

        // Write 0x01, repeated START, read one byte
        txQ.push_back(8'hC3);
        refreshTx();
        txBase = txCount;
        startCond();
        writeByte(8'h90, ack, lat);
        check("rs wr addr ack", {31'd0, ack}, {31'd0, ACK});
        expRx.push_back(8'h01);
        writeByte(8'h01, ack, lat);
        check("rs wr data ack", {31'd0, ack}, {31'd0, ACK});
        repStart();
        check("rs Addressed drop", {31'd0, bus.Addressed}, 32'd0);
        writeByte(8'h91, ack, lat);
        check("rs rd addr ack", {31'd0, ack}, {31'd0, ACK});
        readByte(NACK, rb);
        check("rs rd byte", {24'd0, rb}, 32'hC3);
        stopCond();
        check("rs RxData", {24'd0, bus.RxData}, 32'h01);
        check("rs txreq count", txCount - txBase, 1);

        // Reset during 4th address bit
        startCond();
        bitSlot(1'b1);
        bitSlot(1'b0);
        bitSlot(1'b0);
        waitClk(6);
        sdaM = 1'b1;
        #2 Reset = 1'b1;
        #1;
        check("mid rst SDAdrive", {31'd0, bus.SDAdrive}, 32'd0);
        check("mid rst Addressed", {31'd0, bus.Addressed}, 32'd0);
        check("mid rst RxData", {24'd0, bus.RxData}, 32'd0);
        waitClk(3);
        sclM = 1'b1;
        sdaM = 1'b1;
        waitClk(2);
        Reset = 1'b0;
        waitClk(10);

        startCond();
        writeByte(8'h90, ack, lat);
        check("post rst addr ack", {31'd0, ack}, {31'd0, ACK});
        expRx.push_back(8'h77);
        writeByte(8'h77, ack, lat);
        check("post rst data ack", {31'd0, ack}, {31'd0, ACK});
        stopCond();
        check("post rst RxData", {24'd0, bus.RxData}, 32'h77);

        check("rx queue drained", expRx.size(), 0);
        check("total rx pulses", rxCount, 3);
        check("rx/tx overlap", overlap, 0);
        check("sda change scl high", sdaHighChg, 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
